// File: rtl/ct_spsram_param_init.sv
// Parametrised single-port SRAM wrapper with hardware init sweep,
// optional output register and read-valid strobe.
module ct_spsram_param_init #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 96,
  parameter int WE_WIDTH   = 96,
  parameter int OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  INIT_REQ,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD,
  output logic                  INIT_BUSY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SLICE = DATA_WIDTH / WE_WIDTH;

  if ((DATA_WIDTH % WE_WIDTH) != 0) begin : g_chk_we
    $error("WE_WIDTH must divide DATA_WIDTH");
  end
  if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_chk_oreg
    $error("OUT_REG must be 0 or 1");
  end

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  s2_vld_q, s2_vld_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [WE_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = '0;
    mem_addr  = A;
    mem_wdata = D;
    rd_en     = 1'b0;
    unique case (state_q)
      S_INIT: begin
        mem_we    = '1;
        mem_addr  = cnt_q;
        mem_wdata = INIT_VAL;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (!CEN && !GWEN) begin
          mem_we = ~WEN;
        end
        rd_en = !CEN && GWEN;
        // the same-cycle access still executes before the sweep starts
        if (INIT_REQ) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
    if (RST) begin
      state_d = S_INIT;
      cnt_d   = '0;
      mem_we  = '0;
      rd_en   = 1'b0;
    end
  end

  always_comb begin
    s1_data_d = s1_data_q;
    s1_vld_d  = rd_en;
    s2_data_d = s2_data_q;
    s2_vld_d  = s1_vld_q;
    if (rd_en) begin
      s1_data_d = mem[A];
    end
    if (s1_vld_q) begin
      s2_data_d = s1_data_q;
    end
    // reset drops any read still in flight
    if (RST) begin
      s1_data_d = '0;
      s1_vld_d  = 1'b0;
      s2_data_d = '0;
      s2_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    s1_data_q <= s1_data_d;
    s1_vld_q  <= s1_vld_d;
    s2_data_q <= s2_data_d;
    s2_vld_q  <= s2_vld_d;
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < WE_WIDTH; i++) begin
      if (mem_we[i]) begin
        mem[mem_addr][i*SLICE +: SLICE] <= mem_wdata[i*SLICE +: SLICE];
      end
    end
  end

  assign Q         = (OUT_REG == 1) ? s2_data_q : s1_data_q;
  assign Q_VLD     = (OUT_REG == 1) ? s2_vld_q : s1_vld_q;
  assign INIT_BUSY = (state_q == S_INIT);

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Bench for ct_spsram_param_init: byte-mask/latency-1 instance and
// bit-mask/latency-2 instance with non-zero init value, driven together.
module tb_ct_spsram_param_init;

  localparam logic [95:0] IV = {12{8'hA5}};
  localparam logic [95:0] ONES = {96{1'b1}};

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  a;
  logic        cen;
  logic        gwen;
  logic [11:0] wen_a;
  logic [95:0] wen_b;
  logic [95:0] d;
  logic        init_req;
  logic [95:0] q_a, q_b;
  logic        vld_a, vld_b;
  logic        busy_a, busy_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always_comb begin
    wen_b = '0;
    for (int i = 0; i < 12; i++) begin
      wen_b[i*8 +: 8] = {8{wen_a[i]}};
    end
  end

  ct_spsram_param_init #(
    .ADDR_WIDTH(9), .DATA_WIDTH(96), .WE_WIDTH(12),
    .OUT_REG(0), .INIT_VAL('0)
  ) dut_a (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen_a), .D(d), .INIT_REQ(init_req),
    .Q(q_a), .Q_VLD(vld_a), .INIT_BUSY(busy_a)
  );

  ct_spsram_param_init #(
    .ADDR_WIDTH(9), .DATA_WIDTH(96), .WE_WIDTH(96),
    .OUT_REG(1), .INIT_VAL(IV)
  ) dut_b (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen_b), .D(d), .INIT_REQ(init_req),
    .Q(q_b), .Q_VLD(vld_b), .INIT_BUSY(busy_b)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [8:0]  a;
    logic [95:0] d;
    logic [11:0] wen;
    logic [95:0] ea;
    logic [95:0] eb;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [95:0] got,
                     input logic [95:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    a     = v.a;
    d     = v.d;
    wen_a = v.wen;
    cen   = !(v.wr || v.rd);
    gwen  = !v.wr;
    @(posedge clk); #1;
    cen = 1'b1;
    if (v.rd) begin
      chk($sformatf("rd%03h_vldA", v.a), vld_a, 1);
      chk($sformatf("rd%03h_qA", v.a), q_a, v.ea);
      chk($sformatf("rd%03h_earlyB", v.a), vld_b, 0);
    end else begin
      chk($sformatf("nr%03h_vldA", v.a), vld_a, 0);
      chk($sformatf("nr%03h_vldB1", v.a), vld_b, 0);
    end
    @(posedge clk); #1;
    if (v.rd) begin
      chk($sformatf("rd%03h_vldB", v.a), vld_b, 1);
      chk($sformatf("rd%03h_qB", v.a), q_b, v.eb);
      chk($sformatf("rd%03h_onceA", v.a), vld_a, 0);
    end else begin
      chk($sformatf("nr%03h_vldB2", v.a), vld_b, 0);
    end
  endtask

  task automatic sweep(input int inj, output int na, output int nb,
                       output int va, output int vb, output int qnz);
    na = 0; nb = 0; va = 0; vb = 0; qnz = 0;
    for (int n = 0; n < 600 && (busy_a || busy_b); n++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      if (vld_a) va++;
      if (vld_b) vb++;
      if (q_a != '0 || q_b != '0) qnz++;
      cen = (n == inj) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    cen = 1'b1;
  endtask

  function automatic vec_t mk(input logic wr, input logic rd,
                              input logic [8:0] ad, input logic [95:0] dd,
                              input logic [11:0] w, input logic [95:0] ea,
                              input logic [95:0] eb);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = ad; v.d = dd;
    v.wen = w; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  int na, nb, va, vb, qnz;

  initial begin
    tbl[0]  = mk(0, 1, 9'h000, '0, 12'hFFF, '0, IV);
    tbl[1]  = mk(0, 1, 9'h0FF, '0, 12'hFFF, '0, IV);
    tbl[2]  = mk(0, 1, 9'h1FF, '0, 12'hFFF, '0, IV);
    tbl[3]  = mk(0, 1, 9'h010, '0, 12'hFFF, '0, IV);
    tbl[4]  = mk(1, 0, 9'h020, ONES, 12'hFFE, '0, '0);
    tbl[5]  = mk(1, 0, 9'h020, {12{8'h11}}, 12'h7FF, '0, '0);
    tbl[6]  = mk(0, 1, 9'h020, '0, 12'h000,
                 96'h11000000_00000000_000000FF,
                 96'h11A5A5A5_A5A5A5A5_A5A5A5FF);
    tbl[7]  = mk(1, 0, 9'h030, ONES, 12'hFFF, '0, '0);
    tbl[8]  = mk(0, 1, 9'h030, '0, 12'hFFF, '0, IV);
    tbl[9]  = mk(1, 0, 9'h001, 96'd1, 12'h000, '0, '0);
    tbl[10] = mk(1, 0, 9'h002, 96'd2, 12'h000, '0, '0);
    tbl[11] = mk(1, 0, 9'h003, 96'd3, 12'h000, '0, '0);
    tbl[12] = mk(1, 0, 9'h005, 96'd7, 12'h000, '0, '0);
    tbl[13] = mk(0, 0, 9'h001, '0, 12'h000, '0, '0);
    tbl[14] = mk(0, 1, 9'h001, '0, 12'h000, 96'd1, 96'd1);

    rst = 1'b1; cen = 1'b1; gwen = 1'b1; wen_a = 12'hFFF;
    a = '0; d = '0; init_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_qA", q_a, '0);
    chk("rst_qB", q_b, '0);
    chk("rst_vldA", vld_a, 0);
    chk("rst_vldB", vld_b, 0);
    chk("rst_busyA", busy_a, 1);
    chk("rst_busyB", busy_b, 1);
    rst = 1'b0;

    // write presented at sweep cycle 5 must be ignored
    gwen = 1'b0; a = 9'h010; d = ONES; wen_a = 12'h000;
    sweep(5, na, nb, va, vb, qnz);
    gwen = 1'b1; wen_a = 12'hFFF;
    chk("sw1_busyA", na, 512);
    chk("sw1_busyB", nb, 512);
    chk("sw1_vld", va + vb, 0);
    chk("sw1_q", qnz, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // back-to-back reads
    cen = 1'b0; gwen = 1'b1; a = 9'h001;
    @(posedge clk); #1;
    a = 9'h002;
    chk("b2b_vA1", vld_a, 1); chk("b2b_qA1", q_a, 96'd1);
    chk("b2b_vB0", vld_b, 0);
    @(posedge clk); #1;
    a = 9'h003;
    chk("b2b_qA2", q_a, 96'd2);
    chk("b2b_vB1", vld_b, 1); chk("b2b_qB1", q_b, 96'd1);
    @(posedge clk); #1;
    cen = 1'b1;
    chk("b2b_vA3", vld_a, 1); chk("b2b_qA3", q_a, 96'd3);
    chk("b2b_vB2", vld_b, 1); chk("b2b_qB2", q_b, 96'd2);
    @(posedge clk); #1;
    chk("b2b_vA4", vld_a, 0);
    chk("b2b_vB3", vld_b, 1); chk("b2b_qB3", q_b, 96'd3);
    @(posedge clk); #1;
    chk("b2b_vB4", vld_b, 0);

    // read immediately after write to same address
    cen = 1'b0; gwen = 1'b0; a = 9'h040; wen_a = 12'h000;
    d = 96'h01234567_89ABCDEF_FEDCBA98;
    @(posedge clk); #1;
    gwen = 1'b1; d = '0;
    @(posedge clk); #1;
    cen = 1'b1;
    chk("raw_qA", q_a, 96'h01234567_89ABCDEF_FEDCBA98);
    @(posedge clk); #1;
    chk("raw_qB", q_b, 96'h01234567_89ABCDEF_FEDCBA98);

    // init request with same-cycle read of 0x005
    cen = 1'b0; gwen = 1'b1; a = 9'h005; init_req = 1'b1;
    @(posedge clk); #1;
    cen = 1'b1; init_req = 1'b0;
    chk("ireq_vA", vld_a, 1); chk("ireq_qA", q_a, 96'd7);
    chk("ireq_vB", vld_b, 0);
    chk("ireq_busyA", busy_a, 1); chk("ireq_busyB", busy_b, 1);
    sweep(-1, na, nb, va, vb, qnz);
    chk("sw2_busyA", na, 512);
    chk("sw2_busyB", nb, 512);
    chk("sw2_vldA", va, 1);
    chk("sw2_vldB", vb, 1);
    chk("sw2_qA", q_a, 96'd7);
    chk("sw2_qB", q_b, 96'd7);
    run_vec(mk(0, 1, 9'h005, '0, 12'hFFF, '0, IV));

    // reset pulsed 300 cycles into a sweep
    run_vec(mk(1, 0, 9'h003, 96'd3, 12'h000, '0, '0));
    run_vec(mk(0, 1, 9'h003, '0, 12'hFFF, 96'd3, 96'd3));
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    chk("mid_busyA", busy_a, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_qA", q_a, '0);
    chk("mid_qB", q_b, '0);
    sweep(-1, na, nb, va, vb, qnz);
    chk("sw3_busyA", na, 512);
    chk("sw3_busyB", nb, 512);
    chk("sw3_vld", va + vb, 0);
    chk("sw3_q", qnz, 0);
    run_vec(mk(0, 1, 9'h001, '0, 12'hFFF, '0, IV));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
